// File: rtl/dmem_responder.sv
// Data-memory responder for the load/store path: RV32I byte/half/word accesses
// with a fixed wait-state delay, a one-cycle response pulse and error reporting.
module dmem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int         WORDS     = 2 ** (ADDR_WIDTH - 2);
  localparam int         LANES     = DATA_WIDTH / 8;
  localparam logic [3:0] WCNT_INIT = 4'(WAIT_STATES);
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wcnt_q;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic accept;
  logic exec;

  logic                  exe_we;
  logic [ADDR_WIDTH-1:0] exe_addr;
  logic [2:0]            exe_funct3;
  logic [DATA_WIDTH-1:0] exe_wdata;
  logic [ADDR_WIDTH-3:0] exe_widx;

  logic                  supported;
  logic                  misaligned;
  logic                  err_c;
  logic [DATA_WIDTH-1:0] word_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [DATA_WIDTH-1:0] load_c;
  logic [LANES-1:0]      be_c;
  logic [DATA_WIDTH-1:0] wd_c;

  assign accept = req_valid && req_ready && !rst;

  // State register.
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the values from before the edge, regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) state_d = NO_WAIT ? RESP : WAIT;
        else        state_d = IDLE;
      end
      WAIT:    if (wcnt_q == 4'd1) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    req_ready = (state_q != WAIT);
    rsp_valid = (state_q == RESP);
  end

  // Request capture and wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      wcnt_q   <= '0;
    end else if (accept) begin
      we_q     <= req_we;
      addr_q   <= req_addr;
      funct3_q <= req_funct3;
      wdata_q  <= req_wdata;
      wcnt_q   <= WCNT_INIT;
    end else if (state_q == WAIT) begin
      wcnt_q   <= wcnt_q - 4'd1;
    end
  end

  // The access executes on the edge entering RESP; with no wait states that is
  // the accepting edge itself, so the live request fields are used directly.
  assign exec       = (state_d == RESP) && !rst;
  assign exe_we     = NO_WAIT ? req_we     : we_q;
  assign exe_addr   = NO_WAIT ? req_addr   : addr_q;
  assign exe_funct3 = NO_WAIT ? req_funct3 : funct3_q;
  assign exe_wdata  = NO_WAIT ? req_wdata  : wdata_q;
  assign exe_widx   = exe_addr[ADDR_WIDTH-1:2];

  // Access checking: funct3[1:0] is the size, funct3[2] the unsigned flag.
  always_comb begin
    supported  = 1'b0;
    misaligned = 1'b0;
    if (exe_we) supported = (exe_funct3 inside {3'b000, 3'b001, 3'b010});
    else        supported = (exe_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    unique case (exe_funct3[1:0])
      2'b01:   misaligned = exe_addr[0];
      2'b10:   misaligned = (exe_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    err_c = !supported || misaligned;
  end

  // Load extraction and extension.
  always_comb begin
    word_c = mem[exe_widx];
    byte_c = word_c[8*exe_addr[1:0] +: 8];
    half_c = exe_addr[1] ? word_c[31:16] : word_c[15:0];
    load_c = '0;
    unique case (exe_funct3)
      3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  load_c = {{16{half_c[15]}}, half_c};
      3'b010:  load_c = word_c;
      3'b100:  load_c = {24'h0, byte_c};
      3'b101:  load_c = {16'h0, half_c};
      default: load_c = '0;
    endcase
  end

  // Store lane enables with the store data replicated across lanes.
  always_comb begin
    be_c = '0;
    wd_c = exe_wdata;
    unique case (exe_funct3[1:0])
      2'b00: begin
        be_c = LANES'(1) << exe_addr[1:0];
        wd_c = {LANES{exe_wdata[7:0]}};
      end
      2'b01: begin
        be_c = exe_addr[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{exe_wdata[15:0]}};
      end
      default: begin
        be_c = '1;
        wd_c = exe_wdata;
      end
    endcase
  end

  // Storage array.
  // NOTE: the memory is cleared on reset because the block must read back zero
  // afterwards; that forces a flop array rather than an inferred RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WORDS; w++) mem[w] <= '0;
    end else if (exec && exe_we && !err_c) begin
      for (int b = 0; b < LANES; b++) begin
        if (be_c[b]) mem[exe_widx][8*b +: 8] <= wd_c[8*b +: 8];
      end
    end
  end

  // Response registers read zero outside the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (exec) begin
      rsp_rdata <= (exe_we || err_c) ? '0 : load_c;
      rsp_err   <= err_c;
    end else begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule
